// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data-memory port between the core (m0) and a DMA/debug loader (m1).
// Round-robin grant with a bounded lock run; read data is steered back to the requester that issued it.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic             last;
  logic [CNT_W-1:0] lock_cnt;
  logic             rsp_v;
  logic             rsp_id;

  logic              in_run;
  logic              hold;
  logic              any_gnt;
  logic              gnt_id;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    in_run  = (lock_cnt != '0) && (lock_cnt < CNT_W'(LOCK_MAX));
    hold    = in_run && (last ? m1_req : m0_req);
    // Grants are suppressed while reset is asserted even if requests are pending.
    any_gnt = rst_n && (m0_req || m1_req);
    if (hold) begin
      gnt_id = last;
    end else if (m0_req && m1_req) begin
      gnt_id = ~last;
    end else begin
      gnt_id = m1_req;
    end

    sel_we    = gnt_id ? m1_we    : m0_we;
    sel_lock  = gnt_id ? m1_lock  : m0_lock;
    sel_addr  = gnt_id ? m1_addr  : m0_addr;
    sel_wdata = gnt_id ? m1_wdata : m0_wdata;

    m0_gnt    = any_gnt && !gnt_id;
    m1_gnt    = any_gnt && gnt_id;
    mem_en    = any_gnt;
    mem_we    = any_gnt && sel_we;
    mem_addr  = any_gnt ? sel_addr  : '0;
    mem_wdata = any_gnt ? sel_wdata : '0;

    m0_rvalid = rsp_v && !rsp_id;
    m1_rvalid = rsp_v && rsp_id;
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      lock_cnt <= '0;
      rsp_v    <= 1'b0;
      rsp_id   <= 1'b0;
    end else if (any_gnt) begin
      last   <= gnt_id;
      rsp_v  <= !sel_we;
      rsp_id <= gnt_id;
      // A locked run only extends when the same owner keeps the port inside the bound.
      if (!sel_lock) begin
        lock_cnt <= '0;
      end else if ((gnt_id == last) && in_run) begin
        lock_cnt <= lock_cnt + CNT_W'(1);
      end else begin
        lock_cnt <= CNT_W'(1);
      end
    end else begin
      lock_cnt <= '0;
      rsp_v    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a grant/response model checks every cycle,
// directed scenarios pin the model with hand-computed values.
module tb_dmem_arbiter;

  localparam int LOCK_MAX = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  // memory behind the port, and the model's own copy of what it should hold
  logic [31:0] mem_arr [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64] = '{default: 32'h0};

  // model state: owner of the last grant, length of its current locked run, pending read
  int          mlast = 1;
  int          mrun  = 0;
  bit          mrv   = 1'b0;
  int          mid   = 0;
  logic [31:0] mdata = 32'h0;
  bit          prev_g0, prev_g1;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr[7:2]];
    end
  end

  task automatic chk1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_step();
    int          eg;
    bit          r0, r1, owner_req;
    bit          ewe, elock;
    logic [31:0] eaddr, ewdata;
    if (!rst_n) begin
      chk1("rst_m0_gnt", m0_gnt, 1'b0);
      chk1("rst_m1_gnt", m1_gnt, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
      chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
      chk32("rst_m0_rdata", m0_rdata, 32'h0);
      mlast = 1; mrun = 0; mrv = 1'b0; mid = 0;
      prev_g0 = 1'b0; prev_g1 = 1'b0;
      return;
    end
    r0 = m0_req; r1 = m1_req;
    owner_req = (mlast == 0) ? r0 : r1;
    if (mrun >= 1 && mrun < LOCK_MAX && owner_req) eg = mlast;
    else if (r0 && r1)                             eg = 1 - mlast;
    else if (r0)                                   eg = 0;
    else if (r1)                                   eg = 1;
    else                                           eg = -1;

    ewe    = (eg == 0) ? m0_we    : (eg == 1) ? m1_we    : 1'b0;
    elock  = (eg == 0) ? m0_lock  : (eg == 1) ? m1_lock  : 1'b0;
    eaddr  = (eg == 0) ? m0_addr  : (eg == 1) ? m1_addr  : 32'h0;
    ewdata = (eg == 0) ? m0_wdata : (eg == 1) ? m1_wdata : 32'h0;

    chk1("m0_gnt", m0_gnt, eg == 0);
    chk1("m1_gnt", m1_gnt, eg == 1);
    chk1("mem_en", mem_en, eg >= 0);
    chk1("mem_we", mem_we, ewe);
    chk32("mem_addr", mem_addr, eaddr);
    chk32("mem_wdata", mem_wdata, ewdata);
    chk1("m0_rvalid", m0_rvalid, mrv && mid == 0);
    chk1("m1_rvalid", m1_rvalid, mrv && mid == 1);
    chk32("m0_rdata", m0_rdata, (mrv && mid == 0) ? mdata : 32'h0);
    chk32("m1_rdata", m1_rdata, (mrv && mid == 1) ? mdata : 32'h0);

    prev_g0 = m0_gnt; prev_g1 = m1_gnt;
    if (eg >= 0) begin
      if (!elock)                                         mrun = 0;
      else if (eg == mlast && mrun >= 1 && mrun < LOCK_MAX) mrun = mrun + 1;
      else                                                mrun = 1;
      mlast = eg;
      mrv   = !ewe;
      mid   = eg;
      if (ewe) ref_mem[eaddr[7:2]] = ewdata;
      else     mdata = ref_mem[eaddr[7:2]];
    end else begin
      mrun = 0;
      mrv  = 1'b0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_lock = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4; m1_wdata = 32'h0; m1_lock = 1'b0;

    // reset with both requesting, then tie goes to m0 and round-robin alternates
    sample();
    chk1("d_rst_gnt0", m0_gnt, 1'b0);
    chk1("d_rst_gnt1", m1_gnt, 1'b0);
    step(); rst_n = 1'b1;
    sample();
    chk1("d_first_gnt0", m0_gnt, 1'b1);
    chk1("d_first_gnt1", m1_gnt, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step(); sample();
      chk1("d_rr_gnt0", m0_gnt, i % 2 == 0);
      chk1("d_rr_gnt1", m1_gnt, i % 2 == 1);
    end
    step(); m0_req = 1'b0; m1_req = 1'b0; sample();

    // write then read back through m1
    step(); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'hDEADBEEF; sample();
    chk1("d_wr_gnt1", m1_gnt, 1'b1);
    step(); m1_we = 1'b0; sample();
    chk1("d_rd_gnt1", m1_gnt, 1'b1);
    chk1("d_wr_no_rvalid", m1_rvalid, 1'b0);
    step(); m1_req = 1'b0; sample();
    chk1("d_rd_rvalid1", m1_rvalid, 1'b1);
    chk32("d_rd_rdata1", m1_rdata, 32'hDEADBEEF);
    chk1("d_rd_rvalid0", m0_rvalid, 1'b0);

    // lock bound: m0 locked for LOCK_MAX grants, then m1
    step(); m0_req = 1'b1; m0_lock = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; m1_req = 1'b1;
    sample();
    chk1("d_lock_gnt0", m0_gnt, 1'b1);
    for (int i = 1; i < LOCK_MAX; i++) begin
      step(); sample();
      chk1("d_lock_gnt0", m0_gnt, 1'b1);
    end
    step(); sample();
    chk1("d_lock_bound_gnt1", m1_gnt, 1'b1);
    step(); m0_req = 1'b0; m0_lock = 1'b0; m1_req = 1'b0; sample();

    // lock release: three locked grants, fourth without lock, then m1
    step(); m0_req = 1'b1; m0_lock = 1'b1; m1_req = 1'b1; sample();
    chk1("d_rel_gnt0_a", m0_gnt, 1'b1);
    step(); sample();
    chk1("d_rel_gnt0_b", m0_gnt, 1'b1);
    step(); sample();
    chk1("d_rel_gnt0_c", m0_gnt, 1'b1);
    step(); m0_lock = 1'b0; sample();
    chk1("d_rel_gnt0_d", m0_gnt, 1'b1);
    step(); sample();
    chk1("d_rel_gnt1", m1_gnt, 1'b1);
    step(); m0_req = 1'b0; m1_req = 1'b0; sample();

    // reset while a read response is pending
    step(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8; sample();
    chk1("d_mr_gnt0", m0_gnt, 1'b1);
    step(); m0_req = 1'b0; rst_n = 1'b0; sample();
    chk1("d_mr_rvalid_rst", m0_rvalid, 1'b0);
    step(); rst_n = 1'b1; sample();
    chk1("d_mr_rvalid_after", m0_rvalid, 1'b0);
    step(); m0_req = 1'b1; m1_req = 1'b1; sample();
    chk1("d_mr_last_gnt0", m0_gnt, 1'b1);
    chk1("d_mr_last_gnt1", m1_gnt, 1'b0);
    step(); m0_req = 1'b0; m1_req = 1'b0; sample();

    // randomized traffic; requests held until granted
    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n = ($urandom_range(0, 399) != 0);
      if (!m0_req || prev_g0) begin
        m0_req   = ($urandom_range(0, 3) != 0);
        m0_we    = $urandom_range(0, 1) == 1;
        m0_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        m0_wdata = $urandom;
        m0_lock  = ($urandom_range(0, 3) != 0);
      end
      if (!m1_req || prev_g1) begin
        m1_req   = ($urandom_range(0, 2) != 0);
        m1_we    = $urandom_range(0, 1) == 1;
        m1_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        m1_wdata = $urandom;
        m1_lock  = ($urandom_range(0, 1) == 1);
      end
      sample();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
